// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^m) arithmetic helpers and sizing functions for the RS checker
package rs_pkg;

  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                         input int w, input logic [31:0] poly);
    logic [31:0] p, x, bb;
    p = '0;
    x = a;
    bb = b;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        if (bb[0]) p = p ^ x;
        bb = bb >> 1;
        x = x << 1;
        if ((x >> w) != 0) x = x ^ poly;
      end
    end
    return p;
  endfunction

  function automatic logic [31:0] gf_pow_alpha(input int e, input int w, input logic [31:0] poly);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < e; i++) r = gf_mul(r, 32'd2, w, poly);
    return r;
  endfunction

  function automatic int t_of(input int n, input int k);
    return (n - k) / 2;
  endfunction

  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_syndrome_engine.sv
// rs_syndrome_engine: 2T Horner syndrome registers; nz flags a nonzero syndrome including the current symbol
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int N         = 255,
  parameter int K         = 239,
  parameter int PRIM_POLY = 'h11D,
  parameter int FCR       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [SYM_W-1:0] din,
  output logic             nz
);
  localparam int NS = 2 * t_of(N, K);
  logic [SYM_W-1:0] s     [NS];
  logic [SYM_W-1:0] s_nxt [NS];
  logic [NS-1:0]    nzv;
  for (genvar j = 0; j < NS; j++) begin : g_s
    localparam logic [31:0] A = gf_pow_alpha(FCR + j, SYM_W, 32'(PRIM_POLY));
    assign s_nxt[j] = SYM_W'(gf_mul(32'(s[j]), A, SYM_W, 32'(PRIM_POLY))) ^ din;
    assign nzv[j] = |s_nxt[j];
    // clear wins over enable so the next codeword starts from zero
    always_ff @(posedge clk or negedge reset)
      if (!reset) s[j] <= '0;
      else if (clr) s[j] <= '0;
      else if (en) s[j] <= s_nxt[j];
  end
  assign nz = |nzv;
endmodule

// File: rtl/rs_syndrome_checker.sv
// rs_syndrome_checker: streaming RS syndrome check with NUM_BUF data buffers; RS_ERR_COUNT_EN adds err_count
module rs_syndrome_checker
  import rs_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int N         = 255,
  parameter int K         = 239,
  parameter int PRIM_POLY = 'h11D,
  parameter int FCR       = 0,
  parameter int NUM_BUF   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_err,
  output logic             out_frame_err
`ifdef RS_ERR_COUNT_EN
  , output logic [15:0]    err_count
`endif
);
  localparam int WW = idx_w(N);
  localparam int RW = idx_w(K);
  localparam int PW = idx_w(NUM_BUF);
  localparam int OW = $clog2(NUM_BUF + 1);
  localparam logic [WW-1:0] W_LAST = WW'(N - 1);
  localparam logic [WW-1:0] W_K = WW'(K);
  localparam logic [RW-1:0] R_LAST = RW'(K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_BUF - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(NUM_BUF);
  logic [SYM_W-1:0]   mem [NUM_BUF][K];
  logic [WW-1:0]      widx;
  logic [RW-1:0]      ridx;
  logic [PW-1:0]      wptr, rptr;
  logic [OW-1:0]      occ;
  logic [NUM_BUF-1:0] b_err, b_ferr;
  logic               fsticky, nz, wr, rd, done, rel, fbad;
  always_comb begin
    in_ready      = occ < OCC_FULL;
    out_valid     = occ != '0;
    wr            = in_valid & in_ready;
    rd            = out_valid & out_ready;
    done          = wr & (widx == W_LAST);
    rel           = rd & (ridx == R_LAST);
    fbad          = in_last ^ (widx == W_LAST);
    out_data      = out_valid ? mem[rptr][ridx] : '0;
    out_last      = out_valid & (ridx == R_LAST);
    out_err       = out_valid & b_err[rptr];
    out_frame_err = out_valid & b_ferr[rptr];
  end
  rs_syndrome_engine #(
    .SYM_W(SYM_W), .N(N), .K(K), .PRIM_POLY(PRIM_POLY), .FCR(FCR)
  ) u_syn (
    .clk(clk), .reset(reset), .clr(done), .en(wr), .din(in_data), .nz(nz)
  );
  // parity symbols only feed the syndromes; only data indices land in the buffer
  always_ff @(posedge clk)
    if (wr && widx < W_K) mem[wptr][RW'(widx)] <= in_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      widx    <= '0;
      ridx    <= '0;
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      b_err   <= '0;
      b_ferr  <= '0;
      fsticky <= 1'b0;
    end else begin
      if (wr) begin
        widx    <= done ? '0 : widx + 1'b1;
        fsticky <= done ? 1'b0 : fsticky | fbad;
      end
      if (done) begin
        b_err[wptr]  <= nz;
        b_ferr[wptr] <= fsticky | fbad;
        wptr         <= wptr == P_LAST ? '0 : wptr + 1'b1;
      end
      if (rd) ridx <= rel ? '0 : ridx + 1'b1;
      if (rel) rptr <= rptr == P_LAST ? '0 : rptr + 1'b1;
      occ <= occ + OW'(done) - OW'(rel);
    end
`ifdef RS_ERR_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_count <= '0;
    else if (done && nz && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule
